// File: rtl/xadac_pkg.sv
// ---------------------------------------------------------------------------
// xadac_pkg
// Shared sizes and types for the XADAC coprocessor path.
//   NoVs     : number of vector source operands per instruction
//   NoVec    : number of architectural vector registers
//   SbLen    : number of transaction IDs the scoreboard can track
//   IdT      : transaction ID type
//   VecAddrT : vector register address type
//   SbCntT   : outstanding-transaction counter (must hold 0..SbLen)
// vec_hazard() returns the RAW|WAW hazard bit for a request against a
// pending-write vector. The decoder can reuse it as well.
// ---------------------------------------------------------------------------
package xadac_pkg;

  localparam int unsigned NoVs         = 3;
  localparam int unsigned NoVec        = 32;
  localparam int unsigned SbLen        = 16;
  localparam int unsigned IdWidth      = $clog2(SbLen);
  localparam int unsigned VecAddrWidth = $clog2(NoVec);

  typedef logic [IdWidth-1:0]      IdT;
  typedef logic [VecAddrWidth-1:0] VecAddrT;
  typedef logic [IdWidth:0]        SbCntT;

  // RAW: any enabled source reads a register with a pending write.
  // WAW: the destination is written and already has a pending write.
  function automatic logic vec_hazard(
    input logic [NoVec-1:0]       pend,
    input VecAddrT [NoVs-1:0]     vs_addr,
    input logic [NoVs-1:0]        vs_read,
    input VecAddrT                vd_addr,
    input logic                   vd_clobber
  );
    logic hz;
    hz = vd_clobber && pend[vd_addr];
    for (int i = 0; i < int'(NoVs); i++) begin
      if (vs_read[i] && pend[vs_addr[i]]) begin
        hz = 1'b1;
      end
    end
    return hz;
  endfunction

endpackage

// File: rtl/xadac_vec_sb.sv
// ---------------------------------------------------------------------------
// xadac_vec_sb
// Vector-register scoreboard and issue gate between decode and execute.
// It tracks pending vector-register writes and in-flight transaction IDs. It
// holds off requests with RAW/WAW hazards or a reused ID, and clears state
// as execute responses retire.
// Ports:
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   iss_*                : issue request (valid/ready handshake + payload)
//   ret_*                : retiring execute response (always accepted)
//   flush_i              : synchronous clear of all tracking state
//   outstanding_o        : registered count of in-flight IDs
//   busy_o               : registered, outstanding_o != 0
//   ret_err_o            : registered one-cycle pulse on retire of an unknown ID
// ---------------------------------------------------------------------------
module xadac_vec_sb
  import xadac_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 iss_valid_i,
  output logic                 iss_ready_o,
  input  IdT                   iss_id_i,
  input  VecAddrT [NoVs-1:0]   iss_vs_addr_i,
  input  logic [NoVs-1:0]      iss_vs_read_i,
  input  VecAddrT              iss_vd_addr_i,
  input  logic                 iss_vd_clobber_i,
  input  logic                 ret_valid_i,
  input  IdT                   ret_id_i,
  input  VecAddrT              ret_vd_addr_i,
  input  logic                 ret_vd_write_i,
  input  logic                 flush_i,
  output SbCntT                outstanding_o,
  output logic                 busy_o,
  output logic                 ret_err_o
);

  logic [NoVec-1:0] pend_q, pend_d;
  IdT [NoVec-1:0]   owner_q, owner_d;
  logic [SbLen-1:0] infl_q, infl_d;
  SbCntT            cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             ret_err_q, ret_err_d;

  logic iss_fire;
  logic ret_hit;

  // Ready only looks at registered state and the request payload, so a
  // retire cannot unblock an instruction in the same cycle.
  always_comb begin
    iss_ready_o = !vec_hazard(pend_q, iss_vs_addr_i, iss_vs_read_i,
                              iss_vd_addr_i, iss_vd_clobber_i)
                  && !infl_q[iss_id_i] && !flush_i;
    iss_fire    = iss_valid_i && iss_ready_o;
    ret_hit     = ret_valid_i && !flush_i && infl_q[ret_id_i];
  end

  // Issue and retire can never touch the same ID or pending register in one
  // cycle (IDB/WAW guarantee that), so their updates are applied independently.
  always_comb begin
    pend_d    = pend_q;
    owner_d   = owner_q;
    infl_d    = infl_q;
    cnt_d     = cnt_q;
    ret_err_d = 1'b0;
    if (flush_i) begin
      pend_d = '0;
      infl_d = '0;
      cnt_d  = '0;
    end else begin
      if (ret_valid_i) begin
        if (ret_hit) begin
          infl_d[ret_id_i] = 1'b0;
          // Only the owning instruction may release a pending write.
          if (ret_vd_write_i && pend_q[ret_vd_addr_i] &&
              owner_q[ret_vd_addr_i] == ret_id_i) begin
            pend_d[ret_vd_addr_i] = 1'b0;
          end
        end else begin
          ret_err_d = 1'b1;
        end
      end
      if (iss_fire) begin
        infl_d[iss_id_i] = 1'b1;
        if (iss_vd_clobber_i) begin
          pend_d[iss_vd_addr_i]  = 1'b1;
          owner_d[iss_vd_addr_i] = iss_id_i;
        end
      end
      cnt_d = cnt_q + SbCntT'(iss_fire) - SbCntT'(ret_hit);
    end
    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q    <= '0;
      infl_q    <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      ret_err_q <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      infl_q    <= infl_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      ret_err_q <= ret_err_d;
    end
  end

  // Owner IDs are only consulted while the matching pend bit is set, so they
  // need no reset.
  always_ff @(posedge clk_i) begin
    owner_q <= owner_d;
  end

  assign outstanding_o = cnt_q;
  assign busy_o        = busy_q;
  assign ret_err_o     = ret_err_q;

endmodule

// File: tb/tb_xadac_vec_sb.sv
// ---------------------------------------------------------------------------
// tb_xadac_vec_sb
// Directed stimulus for the vector scoreboard. Each stimulus cycle pushes the
// hand-computed expected outputs into a queue. A monitor on the falling edge
// pops and compares them against the DUT.
// ---------------------------------------------------------------------------
module tb_xadac_vec_sb;
  import xadac_pkg::*;

  logic               clk;
  logic               rst_n;
  logic               iss_valid;
  logic               iss_ready;
  IdT                 iss_id;
  VecAddrT [NoVs-1:0] iss_vs_addr;
  logic [NoVs-1:0]    iss_vs_read;
  VecAddrT            iss_vd_addr;
  logic               iss_vd_clobber;
  logic               ret_valid;
  IdT                 ret_id;
  VecAddrT            ret_vd_addr;
  logic               ret_vd_write;
  logic               flush;
  SbCntT              outstanding;
  logic               busy;
  logic               ret_err;

  typedef struct {
    string name;
    logic  chk_ready;
    logic  ready;
    SbCntT outs;
    logic  busy;
    logic  err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  xadac_vec_sb dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .iss_valid_i      (iss_valid),
    .iss_ready_o      (iss_ready),
    .iss_id_i         (iss_id),
    .iss_vs_addr_i    (iss_vs_addr),
    .iss_vs_read_i    (iss_vs_read),
    .iss_vd_addr_i    (iss_vd_addr),
    .iss_vd_clobber_i (iss_vd_clobber),
    .ret_valid_i      (ret_valid),
    .ret_id_i         (ret_id),
    .ret_vd_addr_i    (ret_vd_addr),
    .ret_vd_write_i   (ret_vd_write),
    .flush_i          (flush),
    .outstanding_o    (outstanding),
    .busy_o           (busy),
    .ret_err_o        (ret_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs shortly after the rising edge.
  task automatic applyStimulus(
    input logic v, input IdT id, input VecAddrT vs0, input logic rd0,
    input VecAddrT vd, input logic clob,
    input logic rv, input IdT rid, input VecAddrT rvd, input logic rw,
    input logic fl
  );
    @(posedge clk);
    #1;
    iss_valid      = v;
    iss_id         = id;
    iss_vs_addr    = '0;
    iss_vs_addr[0] = vs0;
    iss_vs_read    = '0;
    iss_vs_read[0] = rd0;
    iss_vd_addr    = vd;
    iss_vd_clobber = clob;
    ret_valid      = rv;
    ret_id         = rid;
    ret_vd_addr    = rvd;
    ret_vd_write   = rw;
    flush          = fl;
  endtask

  task automatic idle();
    applyStimulus(1'b0, IdT'(0), '0, 1'b0, '0, 1'b0, 1'b0, IdT'(0), '0, 1'b0, 1'b0);
  endtask

  // Queue the expected outputs for the cycle just driven.
  task automatic checkOutput(input string name, input logic chk_ready,
                             input logic ready, input int outs,
                             input logic bsy, input logic err);
    exp_t e;
    e.name      = name;
    e.chk_ready = chk_ready;
    e.ready     = ready;
    e.outs      = SbCntT'(outs);
    e.busy      = bsy;
    e.err       = err;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every queued expectation against the DUT mid-cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_cmp++;
      if ((mon_e.chk_ready && iss_ready !== mon_e.ready) ||
          outstanding !== mon_e.outs || busy !== mon_e.busy ||
          ret_err !== mon_e.err) begin
        n_err++;
        $display("[TB] FAIL %s: got ready=%b outs=%0d busy=%b err=%b, expected ready=%b outs=%0d busy=%b err=%b",
                 mon_e.name, iss_ready, outstanding, busy, ret_err,
                 mon_e.chk_ready ? mon_e.ready : 1'bx, mon_e.outs,
                 mon_e.busy, mon_e.err);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n          = 1'b0;
    iss_valid      = 1'b0;
    iss_id         = '0;
    iss_vs_addr    = '0;
    iss_vs_read    = '0;
    iss_vd_addr    = '0;
    iss_vd_clobber = 1'b0;
    ret_valid      = 1'b0;
    ret_id         = '0;
    ret_vd_addr    = '0;
    ret_vd_write   = 1'b0;
    flush          = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    idle();
    checkOutput("reset_state", 1'b1, 1'b1, 0, 1'b0, 1'b0);

    // Issue id=3 writing vd=5
    applyStimulus(1'b1, IdT'(3), '0, 1'b0, VecAddrT'(5), 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("issue_id3_fire", 1'b1, 1'b1, 0, 1'b0, 1'b0);

    // RAW: id=4 reads v5, blocked until the retire of id=3 lands
    applyStimulus(1'b1, IdT'(4), VecAddrT'(5), 1'b1, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("raw_blocked", 1'b1, 1'b0, 1, 1'b1, 1'b0);
    applyStimulus(1'b1, IdT'(4), VecAddrT'(5), 1'b1, '0, 1'b0, 1'b1, IdT'(3), VecAddrT'(5), 1'b1, 1'b0);
    checkOutput("raw_no_bypass", 1'b1, 1'b0, 1, 1'b1, 1'b0);
    applyStimulus(1'b1, IdT'(4), VecAddrT'(5), 1'b1, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("raw_released", 1'b1, 1'b1, 0, 1'b0, 1'b0);

    // Make v5 pending again with id=3 (id=4 still in flight)
    applyStimulus(1'b1, IdT'(3), '0, 1'b0, VecAddrT'(5), 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("reissue_id3", 1'b1, 1'b1, 1, 1'b1, 1'b0);
    applyStimulus(1'b0, IdT'(7), '0, 1'b0, VecAddrT'(5), 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("waw_blocked", 1'b1, 1'b0, 2, 1'b1, 1'b0);
    applyStimulus(1'b0, IdT'(3), '0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("id_reuse_blocked", 1'b1, 1'b0, 2, 1'b1, 1'b0);
    applyStimulus(1'b0, IdT'(8), '0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    checkOutput("flush_gates_ready", 1'b1, 1'b0, 2, 1'b1, 1'b0);
    applyStimulus(1'b0, IdT'(3), '0, 1'b0, VecAddrT'(5), 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("after_flush_clear", 1'b1, 1'b1, 0, 1'b0, 1'b0);

    // Simultaneous issue of id=2 and retire of id=1
    applyStimulus(1'b1, IdT'(1), '0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("issue_id1", 1'b1, 1'b1, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, IdT'(2), '0, 1'b0, '0, 1'b0, 1'b1, IdT'(1), '0, 1'b0, 1'b0);
    checkOutput("issue2_retire1", 1'b1, 1'b1, 1, 1'b1, 1'b0);
    applyStimulus(1'b0, IdT'(2), '0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("simul_id2_inflight", 1'b1, 1'b0, 1, 1'b1, 1'b0);
    applyStimulus(1'b0, IdT'(1), '0, 1'b0, '0, 1'b0, 1'b1, IdT'(2), '0, 1'b0, 1'b0);
    checkOutput("simul_id1_free", 1'b1, 1'b1, 1, 1'b1, 1'b0);

    // Spurious retire of id=9
    applyStimulus(1'b0, IdT'(0), '0, 1'b0, '0, 1'b0, 1'b1, IdT'(9), '0, 1'b0, 1'b0);
    checkOutput("spurious_cycle", 1'b1, 1'b1, 0, 1'b0, 1'b0);
    idle();
    checkOutput("ret_err_pulse", 1'b1, 1'b1, 0, 1'b0, 1'b1);
    idle();
    checkOutput("ret_err_one_cycle", 1'b1, 1'b1, 0, 1'b0, 1'b0);

    // Fill all IDs, then every ID must be blocked
    for (int i = 0; i < int'(SbLen); i++) begin
      applyStimulus(1'b1, IdT'(i), '0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      checkOutput($sformatf("fill_%0d", i), 1'b1, 1'b1, i, i != 0, 1'b0);
    end
    for (int i = 0; i < int'(SbLen); i++) begin
      applyStimulus(1'b0, IdT'(i), '0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      checkOutput($sformatf("full_block_%0d", i), 1'b1, 1'b0, int'(SbLen), 1'b1, 1'b0);
    end
    applyStimulus(1'b0, IdT'(0), '0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    checkOutput("full_flush", 1'b1, 1'b0, int'(SbLen), 1'b1, 1'b0);
    idle();
    checkOutput("post_flush_empty", 1'b1, 1'b1, 0, 1'b0, 1'b0);

    // Refill partially, then reset asynchronously mid-burst
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, IdT'(i), '0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      checkOutput($sformatf("refill_%0d", i), 1'b1, 1'b1, i, i != 0, 1'b0);
    end
    applyStimulus(1'b1, IdT'(10), '0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    checkOutput("async_reset", 1'b0, 1'b0, 0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    iss_valid = 1'b0;
    iss_id    = IdT'(0);
    checkOutput("after_reset", 1'b1, 1'b1, 0, 1'b0, 1'b0);
    idle();
    checkOutput("after_reset_idle", 1'b1, 1'b1, 0, 1'b0, 1'b0);

    // Let the monitor drain, bounded
    for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("[TB] FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/xadac_vec_sb.md
# xadac_vec_sb

Vector-register scoreboard and issue gate for the XADAC coprocessor path. It sits between the decode stage and the execute unit. It tracks which vector registers have a pending write and which transaction IDs are in flight. It holds off any instruction with a RAW or WAW hazard or a reused ID, and clears state as execute responses retire.

## Interface
- No parameters; all sizes come from `xadac_pkg`: `NoVs`, `NoVec`, `SbLen`, `IdT`, `VecAddrT`.
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `iss_valid_i` in 1: issue request valid.
- `iss_ready_o` out 1: issue may be accepted.
- `iss_id_i` in IdT: transaction ID of the request.
- `iss_vs_addr_i` in VecAddrT[NoVs]: source vector register addresses.
- `iss_vs_read_i` in NoVs: per-source read enable (from DecRspT.vs_read).
- `iss_vd_addr_i` in VecAddrT: destination vector register.
- `iss_vd_clobber_i` in 1: the instruction writes vd.
- `ret_valid_i` in 1: execute response retiring (always accepted).
- `ret_id_i` in IdT: ID of the retiring response.
- `ret_vd_addr_i` in VecAddrT: retiring destination register.
- `ret_vd_write_i` in 1: the response writes vd.
- `flush_i` in 1: synchronous clear of all tracking state.
- `outstanding_o` out IdWidth+1: number of in-flight IDs.
- `busy_o` out 1: outstanding_o != 0.
- `ret_err_o` out 1: one-cycle pulse when the retiring ID was not in flight.

## Operation
- State:
  - `pend_q[NoVec]`: pending bit per vector register.
  - `owner_q[NoVec]`: IdT of the instruction that owns each pending write.
  - `infl_q[SbLen]`: in-flight bit per ID.
  - `cnt_q`: outstanding count.
- Hazard terms are combinational and use registered state only:
  - RAW: any i with `iss_vs_read_i[i] && pend_q[iss_vs_addr_i[i]]`.
  - WAW: `iss_vd_clobber_i && pend_q[iss_vd_addr_i]`.
  - IDB: `infl_q[iss_id_i]`.
- `iss_ready_o = !RAW && !WAW && !IDB && !flush_i`.
  - It may depend on the request payload but never on `iss_valid_i`.
  - The requester must hold the payload stable while valid and not ready.
- Issue fire (valid && ready):
  - set `infl_q[id]`;
  - if clobber, set `pend_q[vd]` and write `owner_q[vd] = id`;
  - `cnt_q` += 1.
- Retire (`ret_valid_i`, not flush):
  - If `infl_q[ret_id]` is set: clear it and `cnt_q` -= 1.
  - Otherwise: pulse `ret_err_o` next cycle; no other state changes.
  - If `ret_vd_write_i && pend_q[ret_vd] && owner_q[ret_vd] == ret_id`: clear `pend_q[ret_vd]`.
  - A vd write whose owner does not match leaves pend unchanged.
- Simultaneous issue and retire:
  - Both updates apply and `cnt_q` is unchanged.
  - They cannot target the same ID (IDB) or the same pending register (WAW), so no priority rule is needed.
- No retire-to-issue bypass.
- Full: all SbLen IDs in flight means every `iss_id_i` hits IDB. `cnt_q` saturates at SbLen by construction.
- Flush:
  - All `pend_q`, `infl_q` and `cnt_q` clear at the next edge.
  - Retire and issue in that cycle are ignored, and `ret_err_o` is not raised.
- Reset (asynchronous, mid-operation included): all state is 0.
  - `iss_ready_o` is 1 once `rst_ni` is high, subject to IDB/RAW/WAW, all of which are clear.
  - `busy_o` = 0, `outstanding_o` = 0, `ret_err_o` = 0.
- `owner_q` is not reset; it is only read when pend is set.

## Timing
- Issue fire at edge N: the pending/in-flight state is visible to hazard logic in cycle N+1.
- Retire in cycle N: a blocked dependent instruction sees ready in cycle N+1 (one-cycle retire-to-issue latency).
- `ret_err_o` is registered: it is high exactly one cycle after the offending retire.
- `outstanding_o` and `busy_o` are registered and update the cycle after fire/retire.
- `iss_ready_o` is combinational from registered state plus `iss_*` and `flush_i`; there is no path from `ret_*` to `iss_ready_o`.

## Structure
- Add to `xadac_pkg`: `SbCntT = logic [IdWidth:0]`.
- Add to `xadac_pkg`: function `vec_hazard(pend, vs_addr, vs_read, vd_addr, vd_clobber)` returning the RAW|WAW bit, for reuse by the decoder.
- No sub-module is needed; the scoreboard is a single flat module.

## Test plan
- Reset then issue id=3, vd=5, clobber: ready=1 on the fire cycle; next cycle `outstanding_o`=1, `busy_o`=1.
- RAW: after the step above, request id=4 reading vs0=5: ready=0 until ret id=3 vd=5 write in cycle N; ready=1 in N+1.
- WAW and ID reuse:
  - request id=7 clobbering vd=5 while vd=5 is pending: ready=0;
  - request id=3 while id 3 is in flight: ready=0.
- Simultaneous: with id=1 in flight, issue id=2 and retire id=1 in the same cycle: `outstanding_o` stays 1, and `infl[2]`=1, `infl[1]`=0.
- Spurious retire: ret id=9 when idle: `ret_err_o`=1 for exactly one cycle; count stays 0.
- Full/flush/reset:
  - Issue 16 distinct IDs: `outstanding_o`=16 and ready=0 for every ID.
  - `flush_i` for one cycle: next cycle count=0 and ready=1.
  - Repeat the fill, then assert `rst_ni`=0 asynchronously mid-burst: outputs go to zero immediately.
